serial_grid_link: RTL and testbench

Host-side serial port for the grid memory. It accepts a parallel grid word over a valid/ready handshake and serializes it into the memory's serial load path. On request, it drives the memory's rotating output path and deserializes the returned bits into a parallel word. It sits between the external host logic and the grid memory. It drives only load_mode and output_mode; run_mode stays with the system controller, which must hold it low while busy is high.

---
 rtl/serial_grid_link_pkg.sv | 19 +
 rtl/serial_grid_link.sv | 128 ++++++++++++
 tb/tb_serial_grid_link.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_grid_link_pkg.sv
// Shared types and helpers for the grid memory serial link.
//   link_state_e : link FSM states
//   cnt_width()  : bit-counter width able to hold the value n
package serial_grid_link_pkg;

  typedef enum logic [2:0] {
    LINK_IDLE  = 3'd0,
    LINK_LOAD  = 3'd1,
    LINK_READ  = 3'd2,
    LINK_DRAIN = 3'd3,
    LINK_VALID = 3'd4
  } link_state_e;

  // Width of a counter that must represent 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_grid_link.sv
// Host-side serial port for the grid memory.
// Serializes a parallel write word into the memory's load path (MSB first)
// and deserializes the memory's rotating output path into a read word.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   wr_data/wr_valid/wr_ready         host write handshake
//   rd_req                            readback request (sampled in IDLE)
//   rd_data/rd_valid/rd_ready         host read handshake
//   serial_in                         from memory serial_out
//   serial_out, load_mode, output_mode to memory
//   busy                              link not idle
module serial_grid_link #(
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 rd_req,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  input  logic                 serial_in,
  output logic                 serial_out,
  output logic                 load_mode,
  output logic                 output_mode,
  output logic                 busy
);

  import serial_grid_link_pkg::*;

  localparam int unsigned CNT_W = cnt_width(DATA_SIZE);

  link_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_SIZE-1:0] rx_shift_q, rx_shift_d;

  logic                 last_bit;
  logic [DATA_SIZE-1:0] rx_shifted;

  // Counter value seen on the final edge of a LOAD or READ phase.
  assign last_bit   = (cnt_q == CNT_W'(DATA_SIZE - 1));
  assign rx_shifted = {rx_shift_q[DATA_SIZE-2:0], serial_in};

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= LINK_IDLE;
      cnt_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;

    case (state_q)
      LINK_IDLE: begin
        // A write wins over a simultaneous read request.
        if (wr_valid) begin
          tx_shift_d = wr_data;
          cnt_d      = '0;
          state_d    = LINK_LOAD;
        end else if (rd_req) begin
          cnt_d   = '0;
          state_d = LINK_READ;
        end
      end

      LINK_LOAD: begin
        tx_shift_d = {tx_shift_q[DATA_SIZE-2:0], 1'b0};
        cnt_d      = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = LINK_IDLE;
        end
      end

      LINK_READ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The memory's registered serial_out is stale on the first edge.
        if (cnt_q != '0) begin
          rx_shift_d = rx_shifted;
        end
        if (last_bit) begin
          state_d = LINK_DRAIN;
        end
      end

      LINK_DRAIN: begin
        // Catch the last bit still in flight in the memory's output register.
        rx_shift_d = rx_shifted;
        state_d    = LINK_VALID;
      end

      LINK_VALID: begin
        if (rd_ready) begin
          state_d = LINK_IDLE;
        end
      end

      default: begin
        state_d = LINK_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of registered state.
  assign wr_ready    = (state_q == LINK_IDLE);
  assign load_mode   = (state_q == LINK_LOAD);
  assign output_mode = (state_q == LINK_READ);
  assign rd_valid    = (state_q == LINK_VALID);
  assign busy        = (state_q != LINK_IDLE);
  assign serial_out  = tx_shift_q[DATA_SIZE-1];
  assign rd_data     = rx_shift_q;

endmodule

// File: tb/tb_serial_grid_link.sv
// Self-checking bench for serial_grid_link paired with a behavioural grid
// memory (serial load path, rotating output path with registered serial_out).
module tb_serial_grid_link;

  localparam int unsigned N = 8;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic         rd_req;
  logic [N-1:0] rd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic         serial_in;
  logic         serial_out;
  logic         load_mode;
  logic         output_mode;
  logic         busy;

  // Behavioural grid memory.
  logic [N-1:0] mem_q;
  logic         mem_so_q;

  int n_checks;
  int n_errors;

  logic [N-1:0] exp_q[$];

  serial_grid_link #(.DATA_SIZE(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .serial_in   (serial_in),
    .serial_out  (serial_out),
    .load_mode   (load_mode),
    .output_mode (output_mode),
    .busy        (busy)
  );

  assign serial_in = mem_so_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '0;
      mem_so_q <= 1'b0;
    end else if (load_mode) begin
      mem_q <= {mem_q[N-2:0], serial_out};
    end else if (output_mode) begin
      mem_q    <= {mem_q[N-2:0], mem_q[N-1]};
      mem_so_q <= mem_q[N-1];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int cyc;
    cyc = 0;
    while (!wr_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!wr_ready) check_eq("wr_ready_timeout", 64'(wr_ready), 64'd1);
  endtask

  // Write a word; optionally raise rd_req in the same cycle to test priority.
  task automatic do_write(input logic [N-1:0] word, input bit also_rd);
    wait_ready();
    wr_data  = word;
    wr_valid = 1'b1;
    rd_req   = also_rd;
    tick();
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      check_eq("load_mode_hi", 64'(load_mode), 64'd1);
      check_eq("serial_out", 64'(serial_out), 64'(word[N-1-k]));
      if (also_rd) check_eq("output_mode_lo", 64'(output_mode), 64'd0);
      tick();
    end
    check_eq("load_mode_end", 64'(load_mode), 64'd0);
    check_eq("wr_ready_after_load", 64'(wr_ready), 64'd1);
    check_eq("mem_after_write", 64'(mem_q), 64'(word));
  endtask

  // Read back with rd_ready held low for 'hold' VALID cycles.
  task automatic do_read(input logic [N-1:0] mem_exp, input int hold);
    logic [N-1:0] exp_word;
    wait_ready();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    exp_q.push_back(mem_exp);
    for (int k = 0; k < int'(N); k++) begin
      check_eq("output_mode_hi", 64'(output_mode), 64'd1);
      check_eq("rd_valid_early", 64'(rd_valid), 64'd0);
      tick();
    end
    check_eq("drain_output_mode", 64'(output_mode), 64'd0);
    check_eq("drain_busy", 64'(busy), 64'd1);
    check_eq("drain_rd_valid", 64'(rd_valid), 64'd0);
    tick();
    check_eq("rd_valid_rise", 64'(rd_valid), 64'd1);
    exp_word = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check_eq("rd_data_hold", 64'(rd_data), 64'(exp_word));
      check_eq("wr_ready_hold", 64'(wr_ready), 64'd0);
      check_eq("rd_valid_hold", 64'(rd_valid), 64'd1);
      tick();
    end
    check_eq("rd_data", 64'(rd_data), 64'(exp_word));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_eq("rd_valid_drop", 64'(rd_valid), 64'd0);
    check_eq("wr_ready_after_read", 64'(wr_ready), 64'd1);
    check_eq("mem_after_read", 64'(mem_q), 64'(mem_exp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    wr_data  = '0;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    rd_ready = 1'b0;
    repeat (3) tick();

    check_eq("rst_wr_ready", 64'(wr_ready), 64'd1);
    check_eq("rst_serial_out", 64'(serial_out), 64'd0);
    check_eq("rst_load_mode", 64'(load_mode), 64'd0);
    check_eq("rst_output_mode", 64'(output_mode), 64'd0);
    check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_rd_data", 64'(rd_data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    reset_n = 1'b1;
    tick();

    // Plain write, then readback, then two reads with a stalled host.
    do_write(8'hA5, 1'b0);
    tick();
    do_read(8'hA5, 0);
    tick();
    do_read(8'hA5, 5);
    do_read(8'hA5, 5);

    // Write/read collision: write wins.
    do_write(8'h3C, 1'b1);
    do_read(8'h3C, 1);

    // Back-to-back writes with wr_valid held high.
    wait_ready();
    wr_data  = 8'h01;
    wr_valid = 1'b1;
    tick();
    wr_data = 8'hFF;
    for (int k = 0; k < int'(N); k++) begin
      check_eq("b2b_load1", 64'(load_mode), 64'd1);
      tick();
    end
    check_eq("b2b_gap_idle", 64'(wr_ready), 64'd1);
    check_eq("b2b_mem1", 64'(mem_q), 64'h01);
    tick();
    wr_valid = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      check_eq("b2b_load2", 64'(load_mode), 64'd1);
      check_eq("b2b_serial_out", 64'(serial_out), 64'd1);
      tick();
    end
    check_eq("b2b_mem2", 64'(mem_q), 64'hFF);
    do_read(8'hFF, 2);

    // Reset asserted during LOAD cycle 4.
    wait_ready();
    wr_data  = 8'hFF;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    repeat (4) tick();
    check_eq("pre_rst_load", 64'(load_mode), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_load_mode", 64'(load_mode), 64'd0);
    check_eq("mid_rst_serial_out", 64'(serial_out), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_wr_ready", 64'(wr_ready), 64'd1);
    check_eq("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    tick();
    check_eq("rst_hold_rd_valid", 64'(rd_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_idle", 64'(busy), 64'd0);

    // Link still usable after the abort.
    do_write(8'h5A, 1'b0);
    do_read(8'h5A, 0);

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
